// File: rtl/k580vt57_dma_pkg.sv
// rtl/k580vt57_dma_pkg.sv - shared types and constants for the k580vt57 DMA controller
// Contents: transfer FSM states, per-channel transfer modes, register offsets and
// the helper that turns the count-register mode bits into a transfer mode.
package k580_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HREQ,
        S1,
        S2,
        S3
    } dma_state_t;

    typedef enum logic [1:0] {
        VERIFY,
        WRITE,
        READ
    } dma_mode_t;

    localparam logic [3:0] DMA_MODE_REG = 4'd8;

    // Count bits [15:14]: 01 write, 10 read; 00 and the illegal 11 both verify.
    function automatic dma_mode_t decode_mode(input logic [1:0] bits);
        case (bits)
            2'b01:   return WRITE;
            2'b10:   return READ;
            default: return VERIFY;
        endcase
    endfunction

endpackage

// File: rtl/dma_prio_enc.sv
// rtl/dma_prio_enc.sv - 4-way DMA request priority encoder
// Ports:
//   req[3:0]   in   enabled channel requests
//   last[1:0]  in   channel served most recently
//   rotate     in   1 = rotating priority, 0 = fixed (ch0 highest)
//   grant[1:0] out  winning channel (0 when no request)
//   any        out  at least one request present
module dma_prio_enc (
    input  logic [3:0] req,
    input  logic [1:0] last,
    input  logic       rotate,
    output logic [1:0] grant,
    output logic       any
);

    logic [1:0] base;
    logic [1:0] idx;
    logic       found;

    // The search starts just after 'base'; fixed priority is rotation with base=3,
    // so ch0 is examined first. In rotating mode the last served channel is examined last.
    always_comb begin
        grant = 2'd0;
        any   = |req;
        base  = rotate ? last : 2'd3;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/k580vt57_dma.sv
// rtl/k580vt57_dma.sv - KR580VT57 (i8257 subset) 4-channel DMA controller top
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   ce                transfer clock enable; FSM advances only when high
//   iaddr/idata/odata CPU register select, write data, read data (odata combinational)
//   iwe_n, ird_n      CPU strobes; falling iwe_n commits a write, rising ird_n ends a read
//   drq/dack          channel requests / one-hot acknowledges (high S2..S3)
//   hrq/hlda          bus hold handshake with the CPU
//   oaddr             memory address (S1..S3)
//   memr_n/memw_n     memory strobes (low S2..S3 for read/write mode)
//   tc                terminal count, high S2..S3 of the last byte
module k580vt57_dma
    import k580_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int AUTOLOAD = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [3:0]       iaddr,
    input  logic [7:0]       idata,
    output logic [7:0]       odata,
    input  logic             iwe_n,
    input  logic             ird_n,
    input  logic [NCH-1:0]   drq,
    output logic [NCH-1:0]   dack,
    output logic             hrq,
    input  logic             hlda,
    output logic [15:0]      oaddr,
    output logic             memr_n,
    output logic             memw_n,
    output logic             tc
);

    dma_state_t  state_q, state_d;
    logic [15:0] addr_q [NCH];
    logic [15:0] addr_d [NCH];
    logic [15:0] cnt_q  [NCH];
    logic [15:0] cnt_d  [NCH];
    logic [7:0]  mode_q, mode_d;
    logic        bff_q, bff_d;
    logic [3:0]  tc_flag_q, tc_flag_d;
    logic        update_q, update_d;
    logic [1:0]  chan_q, chan_d;
    logic [1:0]  last_q, last_d;
    logic        iwe_n_q, iwe_n_d;
    logic        ird_n_q, ird_n_d;

    logic [3:0]  req;
    logic [1:0]  grant;
    logic        any_req;
    logic        cpu_wr;
    logic        rd_done;
    logic        in_strobe;
    logic        tc_now;
    dma_mode_t   xfer_mode;
    logic [1:0]  wsel;
    logic [3:0]  en_next;
    logic [15:0] word;

    assign req = drq & mode_q[3:0];

    dma_prio_enc u_prio (
        .req    (req),
        .last   (last_q),
        .rotate (mode_q[4]),
        .grant  (grant),
        .any    (any_req)
    );

    // CPU writes are only accepted while the bus is ours (IDLE).
    assign cpu_wr    = iwe_n_q & ~iwe_n & (state_q == IDLE);
    assign rd_done   = ~ird_n_q & ird_n;
    assign in_strobe = (state_q == S2) || (state_q == S3);
    assign xfer_mode = decode_mode(cnt_q[chan_q][15:14]);
    assign tc_now    = (cnt_q[chan_q][13:0] == 14'd0);
    assign wsel      = iaddr[2:1];

    assign hrq    = (state_q != IDLE);
    assign dack   = in_strobe ? (NCH'(1) << chan_q) : '0;
    assign memr_n = ~(in_strobe && (xfer_mode == READ));
    assign memw_n = ~(in_strobe && (xfer_mode == WRITE));
    assign tc     = in_strobe && tc_now;
    // In S1 the channel is not latched yet, so the address follows the live grant.
    assign oaddr  = (state_q == S1) ? addr_q[grant] :
                    in_strobe       ? addr_q[chan_q] : 16'h0000;

    always_comb begin
        odata = 8'h00;
        word  = iaddr[0] ? cnt_q[wsel] : addr_q[wsel];
        if (iaddr < DMA_MODE_REG) begin
            odata = bff_q ? word[15:8] : word[7:0];
        end else if (iaddr == DMA_MODE_REG) begin
            odata = {3'b000, update_q, tc_flag_q};
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        bff_d     = bff_q;
        tc_flag_d = tc_flag_q;
        update_d  = update_q;
        chan_d    = chan_q;
        last_d    = last_q;
        iwe_n_d   = iwe_n;
        ird_n_d   = ird_n;
        en_next   = mode_q[3:0];

        // End of a CPU read: advance the byte pointer, or clear TC flags after a status read.
        if (rd_done) begin
            if (iaddr < DMA_MODE_REG) begin
                bff_d = ~bff_q;
            end else if (iaddr == DMA_MODE_REG) begin
                tc_flag_d = 4'b0000;
            end
        end

        if (cpu_wr) begin
            if (iaddr < DMA_MODE_REG) begin
                bff_d = ~bff_q;
                if (iaddr[0]) begin
                    if (bff_q) cnt_d[wsel][15:8] = idata;
                    else       cnt_d[wsel][7:0]  = idata;
                end else begin
                    if (bff_q) addr_d[wsel][15:8] = idata;
                    else       addr_d[wsel][7:0]  = idata;
                end
                if (wsel == 2'd2) begin
                    update_d = 1'b0;
                    // Autoload keeps ch3 as the reload image of whatever is written to ch2.
                    if (AUTOLOAD != 0 && mode_q[7]) begin
                        if (iaddr[0]) begin
                            if (bff_q) cnt_d[3][15:8] = idata;
                            else       cnt_d[3][7:0]  = idata;
                        end else begin
                            if (bff_q) addr_d[3][15:8] = idata;
                            else       addr_d[3][7:0]  = idata;
                        end
                    end
                end
            end else if (iaddr == DMA_MODE_REG) begin
                mode_d = idata;
                bff_d  = 1'b0;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (ce && any_req) state_d = HREQ;
            end
            HREQ: begin
                if (ce) begin
                    if (!any_req)  state_d = IDLE;
                    else if (hlda) state_d = S1;
                end
            end
            S1: begin
                // Losing the bus before the strobes finish abandons the byte untouched.
                if (!hlda) begin
                    state_d = IDLE;
                end else if (ce) begin
                    if (any_req) begin
                        chan_d  = grant;
                        last_d  = grant;
                        state_d = S2;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            S2: begin
                if (!hlda)   state_d = IDLE;
                else if (ce) state_d = S3;
            end
            S3: begin
                if (ce) begin
                    addr_d[chan_q]       = addr_q[chan_q] + 16'd1;
                    cnt_d[chan_q][13:0]  = cnt_q[chan_q][13:0] - 14'd1;
                    if (tc_now) begin
                        // Applied after the status-read clear so a coincident set wins.
                        tc_flag_d[chan_q] = 1'b1;
                        if (mode_q[6]) begin
                            en_next[chan_q] = 1'b0;
                            mode_d[3:0]     = en_next;
                        end
                        if (AUTOLOAD != 0 && mode_q[7] && chan_q == 2'd2) begin
                            addr_d[2] = addr_q[3];
                            cnt_d[2]  = cnt_q[3];
                            update_d  = 1'b1;
                        end
                    end
                    state_d = ((|(drq & en_next)) && hlda) ? S1 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            for (int i = 0; i < NCH; i++) begin
                addr_q[i] <= 16'h0000;
                cnt_q[i]  <= 16'h0000;
            end
            mode_q    <= 8'h00;
            bff_q     <= 1'b0;
            tc_flag_q <= 4'b0000;
            update_q  <= 1'b0;
            chan_q    <= 2'd0;
            last_q    <= 2'd3;
            iwe_n_q   <= 1'b1;
            ird_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            bff_q     <= bff_d;
            tc_flag_q <= tc_flag_d;
            update_q  <= update_d;
            chan_q    <= chan_d;
            last_q    <= last_d;
            iwe_n_q   <= iwe_n_d;
            ird_n_q   <= ird_n_d;
        end
    end

endmodule

// File: tb/tb_k580vt57_dma.sv
// tb/tb_k580vt57_dma.sv - directed scoreboard bench for k580vt57_dma
module tb_k580vt57_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [3:0]  iaddr;
    logic [7:0]  idata;
    logic [7:0]  odata;
    logic        iwe_n;
    logic        ird_n;
    logic [3:0]  drq;
    logic [3:0]  dack;
    logic        hrq;
    logic        hlda;
    logic        hlda_en;
    logic [15:0] oaddr;
    logic        memr_n;
    logic        memw_n;
    logic        tc;

    typedef struct packed {
        logic [3:0]  dack;
        logic [15:0] addr;
        logic        rd_n;
        logic        wr_n;
        logic        tc;
    } xfer_t;

    xfer_t      sb[$];
    xfer_t      mon_obs;
    xfer_t      mon_exp;
    logic [3:0] prev_dack = 4'b0000;
    int         tests = 0;
    int         fails = 0;

    k580vt57_dma #(.NCH(4), .AUTOLOAD(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .iaddr  (iaddr),
        .idata  (idata),
        .odata  (odata),
        .iwe_n  (iwe_n),
        .ird_n  (ird_n),
        .drq    (drq),
        .dack   (dack),
        .hrq    (hrq),
        .hlda   (hlda),
        .oaddr  (oaddr),
        .memr_n (memr_n),
        .memw_n (memw_n),
        .tc     (tc)
    );

    assign hlda = hrq & hlda_en;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One scoreboard entry per byte, checked when dack first rises (inside S2).
    always @(negedge clk) begin
        if (dack !== 4'b0000 && prev_dack === 4'b0000) begin
            mon_obs = {dack, oaddr, memr_n, memw_n, tc};
            chk("xfer_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                chk("xfer", 32'(mon_obs), 32'(mon_exp));
            end
        end
        prev_dack = dack;
    end

    task automatic push_x(input int ch, input logic [15:0] a, input logic r_n,
                          input logic w_n, input logic t);
        xfer_t x;
        x.dack = 4'b0001 << ch;
        x.addr = a;
        x.rd_n = r_n;
        x.wr_n = w_n;
        x.tc   = t;
        sb.push_back(x);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        iaddr = a; idata = d; iwe_n = 1'b0;
        @(posedge clk); #1;
        iwe_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic wr16(input logic [3:0] a, input logic [15:0] d);
        wr(a, d[7:0]);
        wr(a, d[15:8]);
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [7:0] exp, input string tag);
        @(posedge clk); #1;
        iaddr = a; ird_n = 1'b0;
        #2;
        chk(tag, 32'(odata), 32'(exp));
        @(posedge clk); #1;
        ird_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic rd16_chk(input logic [3:0] a, input logic [15:0] exp, input string tag);
        rd_chk(a, exp[7:0], tag);
        rd_chk(a, exp[15:8], tag);
    endtask

    // Returns just after a negedge, i.e. inside S2 of the last expected byte.
    task automatic wait_sb(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) break;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; ce = 1'b1; iaddr = 4'h0; idata = 8'h00;
        iwe_n = 1'b1; ird_n = 1'b1; drq = 4'b0000; hlda_en = 1'b1;
        #1;
        chk("rst_hrq",    32'(hrq),    32'd0);
        chk("rst_dack",   32'(dack),   32'd0);
        chk("rst_memr_n", 32'(memr_n), 32'd1);
        chk("rst_memw_n", 32'(memw_n), 32'd1);
        chk("rst_tc",     32'(tc),     32'd0);
        chk("rst_oaddr",  32'(oaddr),  32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1: ch2 read burst of 80 bytes
        wr16(4'd4, 16'h76D0);
        wr16(4'd5, 16'h804F);
        wr(4'd8, 8'h04);
        for (int i = 0; i < 80; i++) push_x(2, 16'h76D0 + 16'(i), 1'b0, 1'b1, i == 79);
        drq = 4'b0100;
        wait_sb(400);
        drq = 4'b0000;
        repeat (4) @(posedge clk);
        #1 chk("t1_idle_hrq", 32'(hrq), 32'd0);
        rd_chk(4'd8, 8'h04, "t1_status");
        rd_chk(4'd8, 8'h00, "t1_status_cleared");
        rd16_chk(4'd4, 16'h7720, "t1_ch2_addr");
        rd16_chk(4'd5, 16'hBFFF, "t1_ch2_cnt");

        // 2: autoload of ch2 from ch3
        wr(4'd8, 8'h80);
        wr16(4'd4, 16'h1000);
        wr16(4'd5, 16'h8003);
        wr(4'd8, 8'h84);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) push_x(2, 16'h1000 + 16'(i), 1'b0, 1'b1, i == 3);
        drq = 4'b0100;
        wait_sb(100);
        drq = 4'b0000;
        repeat (4) @(posedge clk);
        rd_chk(4'd8, 8'h14, "t2_status_update");
        rd_chk(4'd8, 8'h10, "t2_status_update_kept");
        rd16_chk(4'd4, 16'h1000, "t2_ch2_addr_reloaded");
        rd16_chk(4'd5, 16'h8003, "t2_ch2_cnt_reloaded");
        rd16_chk(4'd6, 16'h1000, "t2_ch3_addr");
        wr16(4'd4, 16'h2000);
        rd_chk(4'd8, 8'h00, "t2_update_cleared");

        // 3: fixed then rotating priority between ch0 (write) and ch1 (read)
        wr(4'd8, 8'h00);
        wr16(4'd0, 16'h0100);
        wr16(4'd1, 16'h4009);
        wr16(4'd2, 16'h0200);
        wr16(4'd3, 16'h8009);
        wr(4'd8, 8'h03);
        for (int i = 0; i < 4; i++) push_x(0, 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b0);
        drq = 4'b0011;
        wait_sb(100);
        drq = 4'b0000;
        repeat (4) @(posedge clk);
        wr(4'd8, 8'h13);
        push_x(1, 16'h0200, 1'b0, 1'b1, 1'b0);
        push_x(0, 16'h0104, 1'b1, 1'b0, 1'b0);
        push_x(1, 16'h0201, 1'b0, 1'b1, 1'b0);
        push_x(0, 16'h0105, 1'b1, 1'b0, 1'b0);
        drq = 4'b0011;
        wait_sb(100);
        drq = 4'b0000;
        repeat (4) @(posedge clk);

        // 4: hlda drops in S2 of the fifth byte
        wr(4'd8, 8'h02);
        for (int i = 0; i < 5; i++) push_x(1, 16'h0202 + 16'(i), 1'b0, 1'b1, 1'b0);
        drq = 4'b0010;
        wait_sb(100);
        hlda_en = 1'b0;
        @(negedge clk);
        chk("t4_abort_hrq",    32'(hrq),    32'd0);
        chk("t4_abort_dack",   32'(dack),   32'd0);
        chk("t4_abort_memr_n", 32'(memr_n), 32'd1);
        rd16_chk(4'd2, 16'h0206, "t4_ch1_addr_kept");
        rd16_chk(4'd3, 16'h8003, "t4_ch1_cnt_kept");
        push_x(1, 16'h0206, 1'b0, 1'b1, 1'b0);
        push_x(1, 16'h0207, 1'b0, 1'b1, 1'b0);
        hlda_en = 1'b1;
        wait_sb(100);
        drq = 4'b0000;
        repeat (4) @(posedge clk);

        // 5: asynchronous reset in S3
        push_x(1, 16'h0208, 1'b0, 1'b1, 1'b0);
        drq = 4'b0010;
        wait_sb(100);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t5_hrq",    32'(hrq),    32'd0);
        chk("t5_dack",   32'(dack),   32'd0);
        chk("t5_memr_n", 32'(memr_n), 32'd1);
        chk("t5_oaddr",  32'(oaddr),  32'd0);
        drq = 4'b0000;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int a = 0; a < 8; a++) rd16_chk(4'(a), 16'h0000, "t5_reg_zero");
        rd_chk(4'd8, 8'h00, "t5_status_zero");

        // 6: TC-stop on a single byte at FFFF
        wr16(4'd0, 16'hFFFF);
        wr16(4'd1, 16'h8000);
        wr(4'd8, 8'h41);
        push_x(0, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        drq = 4'b0001;
        wait_sb(100);
        repeat (30) @(posedge clk);
        #1 chk("t6_stopped_hrq", 32'(hrq), 32'd0);
        drq = 4'b0000;
        rd16_chk(4'd0, 16'h0000, "t6_addr_wrap");
        rd16_chk(4'd1, 16'hBFFF, "t6_cnt_wrap");
        rd_chk(4'd8, 8'h01, "t6_status");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
